// File: rtl/uart_transmitter.sv
// uart_transmitter: 8-bit UART transmitter with a one-byte holding register.
// Frame: start (0), data bits LSB first, optional even-parity bit, then
// IDLE_BITS high bit periods. Each bit lasts CLKS_PER_BIT clocks.
// Build option: define UART_TX_PARITY_EN to include the parity bit.
//
// Ports:
//   CLOCK_125_p  in   system clock, rising edge
//   RESET        in   asynchronous, active-high reset
//   tx_data[7:0] in   byte to transmit
//   tx_valid     in   tx_data is valid
//   tx_ready     out  holding register empty, byte can be accepted
//   busy         out  a frame is in progress
//   done         out  one-cycle pulse on the last cycle of each frame
//   Tx           out  serial line, idle high
module uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned IDLE_BITS    = 2
) (
  input  logic       CLOCK_125_p,
  input  logic       RESET,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       Tx
);

  // Counter covers the longest state (STOP), so it can never wrap.
  localparam int unsigned STOP_LEN = IDLE_BITS * CLKS_PER_BIT;
  localparam int unsigned CNT_W    = $clog2(STOP_LEN + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_LEN - 1);
  localparam logic [CNT_W-1:0] DONE_AT   = CNT_W'(STOP_LEN - 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       hold, hold_n;
  logic             tx_ready_n, busy_n, done_n, tx_n;
  logic             load;
  logic             accept;
`ifdef UART_TX_PARITY_EN
  logic             par, par_n;
`endif

  // tx_ready doubles as the "holding register empty" flag.
  assign accept = tx_valid & tx_ready;

  // Next-state and datapath logic.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_n      = bit_idx;
    shift_n    = shift;
    hold_n     = hold;
    tx_ready_n = tx_ready;
    tx_n       = Tx;
    done_n     = 1'b0;
    load       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n      = par;
`endif

    case (state)
      IDLE: begin
        load = ~tx_ready;
      end
      START: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = DATA;
          tx_n    = shift[0];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            bit_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n   = bit_idx + 1'b1;
            shift_n = shift >> 1;
            tx_n    = shift[1];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        // done is registered, so raise it one cycle ahead of the exit edge.
        done_n = (cnt == DONE_AT);
        if (cnt == STOP_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          load    = ~tx_ready;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        tx_n    = 1'b1;
      end
    endcase

    // Start a frame: byte moves to the shift register, holding register frees.
    if (load) begin
      state_n    = START;
      cnt_n      = '0;
      shift_n    = hold;
      tx_n       = 1'b0;
      tx_ready_n = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_n      = ^hold;
`endif
    end

    // load needs a full register, accept an empty one: never both.
    if (accept) begin
      hold_n     = tx_data;
      tx_ready_n = 1'b0;
    end

    busy_n = (state_n != IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLOCK_125_p or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      hold     <= '0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      Tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      shift    <= shift_n;
      hold     <= hold_n;
      tx_ready <= tx_ready_n;
      busy     <= busy_n;
      done     <= done_n;
      Tx       <= tx_n;
`ifdef UART_TX_PARITY_EN
      par      <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: two instances (1 and 4 clocks per bit), a
// frame-level reference model checked every cycle, plus directed literal checks.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
  localparam logic [11:0] EXP_A5 = 12'hD4A;
  localparam int EXP_LEN4 = 48;
`else
  localparam int PBITS = 0;
  localparam logic [11:0] EXP_A5 = 12'h74A;
  localparam int EXP_LEN4 = 44;
`endif
  localparam int IDLE  = 2;
  localparam int NBITS = 1 + 8 + PBITS + IDLE;
  localparam int FRAME = NBITS;            // frame cycles at 1 clock per bit
  localparam int LOGN  = 2048;

  logic CLOCK_125_p = 1'b0;
  logic RESET = 1'b0;
  logic [7:0] d1 = 8'h00, d4 = 8'h00;
  logic v1 = 1'b0, v4 = 1'b0;
  logic tx_ready1, busy1, done1, tx1;
  logic tx_ready4, busy4, done4, tx4;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic l1_tx [0:LOGN-1];
  logic l1_dn [0:LOGN-1];
  logic l4_tx [0:LOGN-1];
  logic l4_dn [0:LOGN-1];

  always #4 CLOCK_125_p = ~CLOCK_125_p;

  uart_transmitter #(.CLKS_PER_BIT(1), .IDLE_BITS(IDLE)) dut1 (
    .CLOCK_125_p(CLOCK_125_p), .RESET(RESET), .tx_data(d1), .tx_valid(v1),
    .tx_ready(tx_ready1), .busy(busy1), .done(done1), .Tx(tx1));

  uart_transmitter #(.CLKS_PER_BIT(4), .IDLE_BITS(IDLE)) dut4 (
    .CLOCK_125_p(CLOCK_125_p), .RESET(RESET), .tx_data(d4), .tx_valid(v4),
    .tx_ready(tx_ready4), .busy(busy4), .done(done4), .Tx(tx4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  bit         m_active [2] = '{1'b0, 1'b0};
  bit         m_full   [2] = '{1'b0, 1'b0};
  int         m_elapsed[2] = '{0, 0};
  logic [7:0] m_frame  [2] = '{8'h00, 8'h00};
  logic [7:0] m_hold   [2] = '{8'h00, 8'h00};

  function automatic int cpb(input int w);
    return (w == 0) ? 1 : 4;
  endfunction

  function automatic int flen(input int w);
    return NBITS * cpb(w);
  endfunction

  // Value of bit position pos of the frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (PBITS == 1 && pos == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic model_step(input int w, input logic v, input logic [7:0] d);
    bit ready_pre;
    ready_pre = !m_full[w];
    if (m_active[w] && m_elapsed[w] < flen(w) - 1) begin
      m_elapsed[w]++;
    end else if (m_full[w]) begin
      m_active[w]  = 1'b1;
      m_elapsed[w] = 0;
      m_frame[w]   = m_hold[w];
      m_full[w]    = 1'b0;
    end else begin
      m_active[w] = 1'b0;
    end
    if (v && ready_pre) begin
      m_hold[w] = d;
      m_full[w] = 1'b1;
    end
  endtask

  function automatic logic exp_tx(input int w);
    if (!m_active[w]) return 1'b1;
    return frame_bit(m_frame[w], m_elapsed[w] / cpb(w));
  endfunction

  function automatic logic exp_done(input int w);
    return m_active[w] && (m_elapsed[w] == flen(w) - 1);
  endfunction

  always @(posedge CLOCK_125_p or posedge RESET) begin
    if (RESET) begin
      for (int w = 0; w < 2; w++) begin
        m_active[w] = 1'b0; m_full[w] = 1'b0; m_elapsed[w] = 0;
      end
    end else begin
      model_step(0, v1, d1);
      model_step(1, v4, d4);
    end
  end

  // Per-cycle compare against the model, and waveform log for directed checks.
  always @(negedge CLOCK_125_p) begin
    check("m_tx_c1",    32'(tx1),       32'(exp_tx(0)));
    check("m_done_c1",  32'(done1),     32'(exp_done(0)));
    check("m_busy_c1",  32'(busy1),     32'(m_active[0]));
    check("m_ready_c1", 32'(tx_ready1), 32'(!m_full[0]));
    check("m_tx_c4",    32'(tx4),       32'(exp_tx(1)));
    check("m_done_c4",  32'(done4),     32'(exp_done(1)));
    check("m_busy_c4",  32'(busy4),     32'(m_active[1]));
    check("m_ready_c4", 32'(tx_ready4), 32'(!m_full[1]));
    if (cyc < LOGN) begin
      l1_tx[cyc] = tx1; l1_dn[cyc] = done1;
      l4_tx[cyc] = tx4; l4_dn[cyc] = done4;
    end
    cyc++;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge CLOCK_125_p);
    #1;
  endtask

  function automatic logic get_tx(input int w, input int idx);
    if (idx < 0 || idx >= LOGN) return 1'bx;
    return (w == 0) ? l1_tx[idx] : l4_tx[idx];
  endfunction

  function automatic logic get_dn(input int w, input int idx);
    if (idx < 0 || idx >= LOGN) return 1'bx;
    return (w == 0) ? l1_dn[idx] : l4_dn[idx];
  endfunction

  // Length of the run of high samples ending just before idx.
  function automatic int ones_before(input int w, input int idx);
    int n = 0;
    for (int j = idx - 1; j >= 0 && j > idx - 64; j--) begin
      if (get_tx(w, j) !== 1'b1) break;
      n++;
    end
    return n;
  endfunction

  // Data byte of a frame whose start bit is at index st.
  function automatic logic [7:0] byte_at(input int w, input int st);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = get_tx(w, st + (k + 1) * cpb(w));
    return b;
  endfunction

  // ---------------- directed stimulus ----------------
  initial begin
    int s;
    int fz, di, bad, z, bz;
    logic [11:0] rec;

    #1 RESET = 1'b1;
    repeat (3) tick();
    check("rst_tx_c1", 32'(tx1), 32'd1);
    check("rst_ready_c1", 32'(tx_ready1), 32'd1);
    check("rst_busy_c1", 32'(busy1), 32'd0);
    check("rst_done_c1", 32'(done1), 32'd0);
    check("rst_tx_c4", 32'(tx4), 32'd1);
    check("rst_ready_c4", 32'(tx_ready4), 32'd1);
    RESET = 1'b0;
    repeat (2) tick();

    // 0xA5 at 1 clock per bit
    s = cyc - 1; d1 = 8'hA5; v1 = 1'b1;
    tick(); v1 = 1'b0;
    repeat (FRAME + 3) tick();
    check("a5_latency_high", 32'(get_tx(0, s + 1)), 32'd1);
    rec = '0;
    for (int i = 0; i < FRAME; i++) rec[i] = get_tx(0, s + 2 + i);
    check("a5_bits", 32'(rec), 32'(EXP_A5));
    check("a5_done_last", 32'(get_dn(0, s + 1 + FRAME)), 32'd1);
    check("a5_done_prev", 32'(get_dn(0, s + FRAME)), 32'd0);
    check("a5_done_after", 32'(get_dn(0, s + 2 + FRAME)), 32'd0);
    check("a5_idle_after", 32'(get_tx(0, s + 2 + FRAME)), 32'd1);

    // 0x07: odd number of ones, parity bit must be 1
    s = cyc - 1; d1 = 8'h07; v1 = 1'b1;
    tick(); v1 = 1'b0;
    repeat (FRAME + 3) tick();
    rec = '0;
    for (int i = 0; i < FRAME; i++) rec[i] = get_tx(0, s + 2 + i);
    check("p07_data", 32'(rec[8:1]), 32'h07);
`ifdef UART_TX_PARITY_EN
    check("p07_parity_bit", 32'(rec[9]), 32'd1);
    check("p07_rx_parity_err", 32'(^rec[9:1]), 32'd0);
`else
    check("p07_stop_bit", 32'(rec[9]), 32'd1);
`endif

    // back-to-back: second byte buffered while busy, third offer ignored
    s = cyc - 1; d1 = 8'h3C; v1 = 1'b1;
    tick();
    check("b2b_ready_after_accept", 32'(tx_ready1), 32'd0);
    d1 = 8'hC3;
    tick();
    check("b2b_ready_frame_started", 32'(tx_ready1), 32'd1);
    tick();
    check("b2b_ready_buffered", 32'(tx_ready1), 32'd0);
    d1 = 8'hFF;
    repeat (5) tick();
    v1 = 1'b0;
    repeat (2 * FRAME + 4) tick();
    check("b2b_second_start", 32'(get_tx(0, s + 2 + FRAME)), 32'd0);
    check("b2b_gap_high", 32'(ones_before(0, s + 2 + FRAME)), 32'd2);
    check("b2b_no_overwrite", 32'(byte_at(0, s + 2 + FRAME)), 32'hC3);
    check("b2b_no_third", 32'(get_tx(0, s + 2 + 2 * FRAME)), 32'd1);

    // byte offered exactly on the stop-exit edge starts one edge later
    s = cyc - 1; d1 = 8'h3C; v1 = 1'b1;
    tick(); v1 = 1'b0;
    repeat (FRAME) tick();
    d1 = 8'h5A; v1 = 1'b1;
    tick(); v1 = 1'b0;
    repeat (FRAME + 4) tick();
    check("stopexit_idle_cycle", 32'(get_tx(0, s + 2 + FRAME)), 32'd1);
    check("stopexit_start", 32'(get_tx(0, s + 3 + FRAME)), 32'd0);
    check("stopexit_gap", 32'(ones_before(0, s + 3 + FRAME)), 32'd3);
    check("stopexit_data", 32'(byte_at(0, s + 3 + FRAME)), 32'h5A);

    // 0x80 at 4 clocks per bit
    s = cyc - 1; d4 = 8'h80; v4 = 1'b1;
    tick(); v4 = 1'b0;
    repeat (60) tick();
    fz = -1; di = -1;
    for (int i = s; i < s + 62; i++) begin
      if (fz < 0 && get_tx(1, i) === 1'b0) fz = i;
      if (di < 0 && get_dn(1, i) === 1'b1) di = i;
    end
    check("c4_latency", 32'(fz - s), 32'd2);
    check("c4_frame_len", 32'(di - fz + 1), 32'(EXP_LEN4));
    bad = 0;
    for (int b = 0; b < NBITS; b++)
      for (int k = 1; k < 4; k++)
        if (get_tx(1, fz + 4 * b + k) !== get_tx(1, fz + 4 * b)) bad++;
    check("c4_bit_hold", 32'(bad), 32'd0);
    check("c4_msb", 32'(get_tx(1, fz + 32)), 32'd1);
    check("c4_data", 32'(byte_at(1, fz)), 32'h80);
`ifdef UART_TX_PARITY_EN
    check("c4_parity", 32'(get_tx(1, fz + 36)), 32'd1);
`endif

    // reset during data bit 3 with a byte buffered
    d4 = 8'h55; v4 = 1'b1;
    tick();
    d4 = 8'hAA;
    tick();
    tick();
    v4 = 1'b0;
    repeat (16) tick();
    check("rst_mid_tx_low", 32'(tx4), 32'd0);
    check("rst_mid_buffered", 32'(tx_ready4), 32'd0);
    #1 RESET = 1'b1;
    #1;
    check("rst_async_tx", 32'(tx4), 32'd1);
    check("rst_async_ready", 32'(tx_ready4), 32'd1);
    check("rst_async_busy", 32'(busy4), 32'd0);
    check("rst_async_done", 32'(done4), 32'd0);
    tick(); tick();
    RESET = 1'b0;
    z = 0; bz = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (tx4 !== 1'b1) z++;
      if (busy4 !== 1'b0) bz++;
    end
    check("rst_no_frame_tx", 32'(z), 32'd0);
    check("rst_no_frame_busy", 32'(bz), 32'd0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
